tdt_dm_rst_seq: RTL and testbench

TDT_DM_RST_SEQ -- requirements
Module: tdt_dm_rst_seq

---
 rtl/tdt_dm_rst_seq.sv | 165 ++++++++++++++++
 tb/tb_tdt_dm_rst_seq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/tdt_dm_rst_seq.sv
// ----------------------------------------------------------------------------
// tdt_dm_rst_seq
//   Debug-module reset sequencer. It turns a level system-reset or hart-reset
//   request from the debug module into an active-low reset pulse of at least
//   PULSE_CYC cycles. It then waits up to TIMEOUT_CYC cycles for the target to
//   acknowledge, and reports completion or timeout.
//
// Parameters
//   PULSE_CYC   (2..1024) request pulse width in sys_apb_clk cycles
//   TIMEOUT_CYC (2..1024) maximum cycles spent waiting for sys_rst_ack
//
// Ports
//   sys_apb_clk        in   clock
//   sys_apb_rst_b      in   asynchronous active-low reset
//   pad_yy_scan_mode   in   scan mode: forces both request_b outputs high
//   pad_yy_scan_rst_b  in   scan reset (not used functionally)
//   dm_ndmreset_req    in   level request for a system reset
//   dm_hartreset_req   in   level request for a hart reset
//   sys_rst_ack        in   reset target has completed reset
//   seq_sys_rst_req_b  out  active-low system reset request
//   seq_hart_rst_req_b out  active-low hart reset request
//   seq_busy           out  sequencer not idle
//   seq_done           out  one-cycle pulse on entry to DONE
//   seq_timeout        out  sticky: last sequence ended by timeout
// ----------------------------------------------------------------------------
module tdt_dm_rst_seq #(
  parameter int PULSE_CYC   = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic sys_apb_clk,
  input  logic sys_apb_rst_b,
  input  logic pad_yy_scan_mode,
  input  logic pad_yy_scan_rst_b,
  input  logic dm_ndmreset_req,
  input  logic dm_hartreset_req,
  input  logic sys_rst_ack,
  output logic seq_sys_rst_req_b,
  output logic seq_hart_rst_req_b,
  output logic seq_busy,
  output logic seq_done,
  output logic seq_timeout
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ASSERT   = 2'd1,
    S_WAIT_ACK = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  localparam logic       TYPE_SYS   = 1'b1;
  localparam logic       TYPE_HART  = 1'b0;
  localparam logic [9:0] PULSE_LAST = 10'(PULSE_CYC - 1);
  localparam logic [9:0] TMO_LAST   = 10'(TIMEOUT_CYC - 1);
  localparam logic [9:0] CNT_MAX    = 10'h3FF;

  state_t     r_state;
  logic [9:0] r_cnt;
  logic       r_type;
  logic       r_sys_b;
  logic       r_hart_b;
  logic       r_busy;
  logic       r_done;
  logic       r_timeout;

  // Scan reset is deliberately not routed anywhere.
  logic w_unused_scan_rst;
  assign w_unused_scan_rst = pad_yy_scan_rst_b;

  // The single counter serves as pulse counter in ASSERT and timeout counter
  // in WAIT_ACK. Every state entry below overrides it with 0.
  logic [9:0] w_cnt_inc;
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 10'd1;

  always_ff @(posedge sys_apb_clk or negedge sys_apb_rst_b) begin
    if (!sys_apb_rst_b) begin
      r_state   <= S_IDLE;
      r_cnt     <= 10'd0;
      r_type    <= TYPE_SYS;
      r_sys_b   <= 1'b1;
      r_hart_b  <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_cnt  <= w_cnt_inc;
      case (r_state)
        S_IDLE: begin
          r_cnt <= 10'd0;
          if (dm_ndmreset_req || dm_hartreset_req) begin
            // ndmreset has priority when both requests are high.
            r_state   <= S_ASSERT;
            r_type    <= dm_ndmreset_req ? TYPE_SYS : TYPE_HART;
            r_sys_b   <= ~dm_ndmreset_req;
            r_hart_b  <= dm_ndmreset_req;
            r_busy    <= 1'b1;
            r_timeout <= 1'b0;
          end
        end

        S_ASSERT: begin
          if (r_type == TYPE_HART && dm_ndmreset_req) begin
            // Escalate hart reset to system reset; restart the full pulse.
            r_type   <= TYPE_SYS;
            r_cnt    <= 10'd0;
            r_sys_b  <= 1'b0;
            r_hart_b <= 1'b1;
          end else if (r_cnt == PULSE_LAST) begin
            r_state  <= S_WAIT_ACK;
            r_cnt    <= 10'd0;
            r_sys_b  <= 1'b1;
            r_hart_b <= 1'b1;
          end
        end

        S_WAIT_ACK: begin
          if (r_type == TYPE_HART && dm_ndmreset_req) begin
            r_state  <= S_ASSERT;
            r_type   <= TYPE_SYS;
            r_cnt    <= 10'd0;
            r_sys_b  <= 1'b0;
            r_hart_b <= 1'b1;
          end else if (sys_rst_ack) begin
            // Ack is checked first, so it wins over a coincident timeout.
            r_state <= S_DONE;
            r_cnt   <= 10'd0;
            r_done  <= 1'b1;
          end else if (r_cnt == TMO_LAST) begin
            r_state   <= S_DONE;
            r_cnt     <= 10'd0;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
          end
        end

        S_DONE: begin
          // Hold until the debug module drops both requests, so a request
          // level that is still high does not restart the sequence.
          if (!dm_ndmreset_req && !dm_hartreset_req) begin
            r_state <= S_IDLE;
            r_cnt   <= 10'd0;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state  <= S_IDLE;
          r_cnt    <= 10'd0;
          r_sys_b  <= 1'b1;
          r_hart_b <= 1'b1;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  // Scan mode releases both requests combinationally and leaves the FSM alone.
  assign seq_sys_rst_req_b  = r_sys_b  | pad_yy_scan_mode;
  assign seq_hart_rst_req_b = r_hart_b | pad_yy_scan_mode;
  assign seq_busy           = r_busy;
  assign seq_done           = r_done;
  assign seq_timeout        = r_timeout;

endmodule

// File: tb/tb_tdt_dm_rst_seq.sv
// ----------------------------------------------------------------------------
// tb_tdt_dm_rst_seq
//   Directed bench for tdt_dm_rst_seq with PULSE_CYC=4 and TIMEOUT_CYC=8.
//   Cycle numbering: cycle 0 is the clock period in which a request is first
//   presented, and cycle c begins at the c-th following rising edge. Outputs
//   are sampled 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_tdt_dm_rst_seq;

  logic clk;
  logic rst_b;
  logic scan_mode;
  logic scan_rst_b;
  logic ndm_req;
  logic hart_req;
  logic ack;
  logic sys_b;
  logic hart_b;
  logic busy;
  logic done;
  logic timeout;

  int n_vec;
  int n_err;

  tdt_dm_rst_seq #(
    .PULSE_CYC  (4),
    .TIMEOUT_CYC(8)
  ) dut (
    .sys_apb_clk       (clk),
    .sys_apb_rst_b     (rst_b),
    .pad_yy_scan_mode  (scan_mode),
    .pad_yy_scan_rst_b (scan_rst_b),
    .dm_ndmreset_req   (ndm_req),
    .dm_hartreset_req  (hart_req),
    .sys_rst_ack       (ack),
    .seq_sys_rst_req_b (sys_b),
    .seq_hart_rst_req_b(hart_b),
    .seq_busy          (busy),
    .seq_done          (done),
    .seq_timeout       (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int c,
                         input logic e_sys, input logic e_hart,
                         input logic e_busy, input logic e_done,
                         input logic e_to);
    chk($sformatf("%s c%0d sys_b", tag, c),   sys_b,   e_sys);
    chk($sformatf("%s c%0d hart_b", tag, c),  hart_b,  e_hart);
    chk($sformatf("%s c%0d busy", tag, c),    busy,    e_busy);
    chk($sformatf("%s c%0d done", tag, c),    done,    e_done);
    chk($sformatf("%s c%0d timeout", tag, c), timeout, e_to);
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst_b      = 1'b0;
    scan_mode  = 1'b0;
    scan_rst_b = 1'b1;
    ndm_req    = 1'b0;
    hart_req   = 1'b0;
    ack        = 1'b0;

    // Reset state, with a request already pending that must not be taken.
    hart_req = 1'b1;
    tick();
    tick();
    chk_all("reset", 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Hart reset; request released in cycle 1 (pulse still full length),
    // ack in cycle 7. Reset is released in the same period the request is
    // presented, so the first edge after release samples it.
    rst_b = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      chk_all("hart", c, 1'b1, !(c >= 1 && c <= 4), (c <= 8), (c == 8), 1'b0);
      hart_req = 1'b0;
      ack      = (c == 7);
    end
    ack = 1'b0;

    // Both requests high: system reset wins. Requests stay high into DONE,
    // so DONE is held until they drop in cycle 7.
    ndm_req  = 1'b1;
    hart_req = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk_all("prio", c, !(c >= 1 && c <= 4), 1'b1, (c <= 7), (c == 6), 1'b0);
      ndm_req  = (c < 7);
      hart_req = (c < 7);
      ack      = (c == 5);
    end
    ack = 1'b0;

    // Escalation: ndmreset raised in the 3rd hart-assert cycle.
    hart_req = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      tick();
      chk_all("esc", c, !(c >= 4 && c <= 7), !(c >= 1 && c <= 3),
              (c <= 10), (c == 10), 1'b0);
      hart_req = (c < 3);
      ndm_req  = (c == 3);
      ack      = (c == 9);
    end
    ack = 1'b0;

    // Timeout: no ack, WAIT_ACK spans cycles 5..12, DONE in 13.
    hart_req = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      tick();
      chk_all("tmo", c, 1'b1, !(c >= 1 && c <= 4), (c <= 13), (c == 13), (c >= 13));
      hart_req = 1'b0;
    end

    // Ack on the last WAIT_ACK cycle wins over the timeout. The new request
    // clears the sticky timeout, and an ack during ASSERT is ignored.
    ndm_req = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      chk_all("ackto", c, !(c >= 1 && c <= 4), 1'b1, (c <= 13), (c == 13), 1'b0);
      ndm_req = 1'b0;
      ack     = (c == 2 || c == 12);
    end
    ack = 1'b0;

    // Scan override during ASSERT, then asynchronous reset mid-sequence.
    hart_req = 1'b1;
    tick();
    chk_all("scan", 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    hart_req  = 1'b0;
    scan_mode = 1'b1;
    #1;
    chk_all("scan on", 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("scan held", 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    scan_mode = 1'b0;
    #1;
    chk_all("scan off", 2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    rst_b = 1'b0;
    #1;
    chk_all("async rst", 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    rst_b = 1'b1;
    tick();
    tick();
    chk_all("post rst", 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
